ising_lattice_engine: RTL and testbench
=======================================

Name: ising_lattice_engine

Overview:
- Parametrised SIDE x SIDE periodic Ising lattice engine with on-chip spin storage, a checkerboard (white/grey) Metropolis update schedule and one 32-bit LFSR.
- Runs a programmed number of sweeps on `start`, then reports magnetisation and pulses `done`.
- Supports spin readback by address and mid-run abort.
- Sits under the host/bus wrapper that previously drove enable_white/enable_grey by hand.

Parameters:
- SIDE, 8: lattice edge length. Must be even and >= 4.
- SWEEPS_W, 16: width of the sweep counter and of `sweeps`.
- SEED, 32'h1ACE_B00C: LFSR reset value and zero-seed substitute. Must be nonzero.
- AW, $clog2(SIDE*SIDE): width of the readback address.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request; accepted only in IDLE.
- abort  in  1  terminate run; takes effect in WHITE/GREY.
- init_en  in  1  sampled with start: 1 = overwrite all spins with init_val.
- init_val  in  1  initial spin value; 1 = +1, 0 = -1.
- seed_we  in  1  sampled with start: 1 = load seed into LFSR.
- seed  in  32  LFSR seed.
- sweeps  in  SWEEPS_W  number of full sweeps; sampled with start.
- thr4  in  32  acceptance threshold for dE = +4 (exp(-4*beta)*2^32).
- thr8  in  32  acceptance threshold for dE = +8.
- rd_addr  in  AW  readback site index, idx = i*SIDE + j.
- rd_spin  out  1  spin at rd_addr. One-cycle registered latency.
- busy  out  1  high in WHITE, GREY and COUNT.
- done  out  1  one-cycle pulse on entering DONE.
- aborted  out  1  valid with done; 1 if the run ended by abort.
- magnet  out  $clog2(SIDE*SIDE)+2  signed magnetisation, 2*popcount - SIDE^2.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; all spins = 1; lfsr=SEED; sweep_cnt=0.
  - busy=0, done=0, aborted=0, magnet=0, rd_spin=0.
- Encoding and geometry:
  - Spin bit 1 = +1, 0 = -1.
  - Site (i,j) is white iff (i+j) is even.
  - Neighbours are (i+/-1 mod SIDE, j) and (i, j+/-1 mod SIDE).
- FSM: IDLE -> WHITE -> GREY -> (WHITE | COUNT) -> DONE -> IDLE.
  - IDLE + start:
    - Apply init_en/init_val to all spins.
    - If seed_we: lfsr = seed, or SEED when seed == 0.
    - Latch sweeps and thr4/thr8; sweep_cnt=0.
    - Go to COUNT if sweeps == 0, else WHITE.
  - WHITE: one cycle. All white sites update in parallel; grey sites hold.
  - GREY: one cycle. All grey sites update in parallel. Increment sweep_cnt; go to COUNT if new count == sweeps, else WHITE.
  - COUNT: one cycle. magnet <= 2*popcount(lattice) - SIDE^2.
  - DONE: one cycle. done=1, then return to IDLE.
  - Latency: done asserts exactly 2*sweeps + 2 cycles after the start cycle.
- Site update, for the active phase:
  - sum = number of +1 neighbours*2 - 4, range -4..4.
  - dE = 2*s*sum.
  - Accept if dE <= 0.
  - Accept if dE == 4 and (r < thr4 or thr4 == 32'hFFFF_FFFF).
  - Accept if dE == 8 and (r < thr8 or thr8 == 32'hFFFF_FFFF).
  - Accepted means the spin flips.
  - r = rotl(lfsr, idx mod 32) XOR (idx*32'h9E37_79B9 mod 2^32).
- LFSR:
  - Galois, taps 32'h8020_0003.
  - Advances once at the end of every WHITE and GREY cycle; holds otherwise.
- Boundary and priority rules:
  - start while not IDLE: ignored.
  - abort in WHITE/GREY: finish the current cycle's update, go to COUNT, aborted=1.
  - abort in IDLE/COUNT/DONE: ignored.
  - abort and the final GREY cycle together: aborted=1.
  - sweep_cnt never wraps: max `sweeps` is 2^SWEEPS_W - 1.
  - Thresholds changed mid-run have no effect; the latched copies are used.
  - rd_spin reflects the lattice state at the previous clock edge. It is valid in every state.
  - magnet holds its value until the next COUNT.
  - reset mid-run: immediate return to reset values; lattice reinitialised to all +1.

Decomposition:
- Package `ising_pkg`:
  - state enum {IDLE, WHITE, GREY, COUNT, DONE}
  - LFSR taps constant
  - hash constant 32'h9E37_79B9
  - SPIN_UP/SPIN_DOWN constants
  - function `is_white(i,j)`
- One sub-module, `ising_site_update`: combinational. Inputs s, 4 neighbours, r, thr4, thr8. Output new spin. Generated per site.

Test Plan:
- init_en=1, init_val=1, thr4=thr8=0, sweeps=3 -> no flips; magnet=+64 (SIDE=8); done 8 cycles after start; aborted=0.
- init_val=1, thr8=32'hFFFF_FFFF, sweeps=1 -> white sites flip after WHITE (checkerboard), grey sites flip in GREY (dE=-8) -> all -1; magnet=-64.
- sweeps=0, init_val=0 -> COUNT then DONE; done 2 cycles after start; magnet=-64; LFSR unchanged.
- sweeps=100, abort pulsed 5 cycles after start -> done 2 cycles later; aborted=1; start during busy ignored.
- After the scenario 2 run, rd_addr=0 then 9 -> rd_spin=0 one cycle after each address; reset asserted mid-run -> busy=0, rd_spin=0 immediately, lattice all +1.
- seed_we=1, seed=0 -> LFSR = SEED; compare the spin pattern after 1 sweep at beta-derived thresholds against the reference model bit-exactly.

Source files
------------

// File: rtl/ising_pkg.sv
// Shared types and constants for the checkerboard Ising lattice engine.
package ising_pkg;

  typedef enum logic [2:0] {IDLE, WHITE, GREY, COUNT, DONE} state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] HASH_K    = 32'h9E37_79B9;
  localparam logic        SPIN_UP   = 1'b1;
  localparam logic        SPIN_DOWN = 1'b0;

  function automatic logic is_white(input int i, input int j);
    return ((i + j) % 2) == 0;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
  endfunction

  // A shift by 32 yields zero, so k == 0 degenerates to the identity.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

endpackage

// File: rtl/ising_lattice_engine_site.sv
// Combinational Metropolis decision for one lattice site.
module ising_site_update
  import ising_pkg::*;
(
  input  logic        i_s,
  input  logic [3:0]  i_nb,
  input  logic [31:0] i_r,
  input  logic [31:0] i_thr4,
  input  logic [31:0] i_thr8,
  output logic        o_spin
);

  logic [2:0] w_aligned;
  logic       w_accept;

  // dE = 4*aligned - 8, so only 3 or 4 aligned neighbours need a random draw.
  always_comb begin
    w_aligned = 3'd0;
    for (int k = 0; k < 4; k++) begin
      w_aligned = w_aligned + {2'b00, (i_nb[k] == i_s)};
    end
    case (w_aligned)
      3'd3:    w_accept = (i_r < i_thr4) || (&i_thr4);
      3'd4:    w_accept = (i_r < i_thr8) || (&i_thr8);
      default: w_accept = 1'b1;
    endcase
    o_spin = w_accept ? ~i_s : i_s;
  end

endmodule

// File: rtl/ising_lattice_engine.sv
// SIDE x SIDE periodic Ising lattice with checkerboard Metropolis sweeps,
// spin readback and magnetisation report.
module ising_lattice_engine
  import ising_pkg::*;
#(
  parameter int          SIDE     = 8,
  parameter int          SWEEPS_W = 16,
  parameter logic [31:0] SEED     = 32'h1ACE_B00C,
  parameter int          AW       = $clog2(SIDE*SIDE)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 init_en,
  input  logic                                 init_val,
  input  logic                                 seed_we,
  input  logic [31:0]                          seed,
  input  logic [SWEEPS_W-1:0]                  sweeps,
  input  logic [31:0]                          thr4,
  input  logic [31:0]                          thr8,
  input  logic [AW-1:0]                        rd_addr,
  output logic                                 rd_spin,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 aborted,
  output logic signed [$clog2(SIDE*SIDE)+1:0]  magnet
);

  localparam int N  = SIDE * SIDE;
  localparam int MW = $clog2(N) + 2;

  function automatic logic [N-1:0] white_mask();
    logic [N-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) begin
      m[k] = is_white(k / SIDE, k % SIDE);
    end
    return m;
  endfunction

  localparam logic [N-1:0] WHITE_MASK = white_mask();

  state_t                r_state;
  state_t                w_next;
  logic [N-1:0]          r_spins;
  logic [N-1:0]          w_new;
  logic [31:0]           r_lfsr;
  logic [SWEEPS_W-1:0]   r_sweep_cnt;
  logic [SWEEPS_W-1:0]   r_sweeps;
  logic [SWEEPS_W-1:0]   w_cnt_inc;
  logic [31:0]           r_thr4;
  logic [31:0]           r_thr8;
  logic [MW-1:0]         r_magnet;
  logic [MW-1:0]         w_pop;
  logic [MW-1:0]         w_magnet;
  logic                  r_aborted;
  logic                  r_rd_spin;
  logic                  w_rd_spin;

  for (genvar gi = 0; gi < SIDE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIDE; gj++) begin : g_col
      localparam int          IDX  = gi * SIDE + gj;
      localparam int          UP   = ((gi + SIDE - 1) % SIDE) * SIDE + gj;
      localparam int          DN   = ((gi + 1) % SIDE) * SIDE + gj;
      localparam int          LF   = gi * SIDE + (gj + SIDE - 1) % SIDE;
      localparam int          RT   = gi * SIDE + (gj + 1) % SIDE;
      localparam logic [31:0] HASH = HASH_K * 32'(IDX);

      logic [31:0] w_r;
      assign w_r = rotl32(r_lfsr, IDX % 32) ^ HASH;

      ising_site_update u_site (
        .i_s    (r_spins[IDX]),
        .i_nb   ({r_spins[UP], r_spins[DN], r_spins[LF], r_spins[RT]}),
        .i_r    (w_r),
        .i_thr4 (r_thr4),
        .i_thr8 (r_thr8),
        .o_spin (w_new[IDX])
      );
    end
  end

  assign w_cnt_inc = r_sweep_cnt + SWEEPS_W'(1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (sweeps == '0) ? COUNT : WHITE;
      WHITE:   w_next = abort ? COUNT : GREY;
      GREY:    w_next = (abort || (w_cnt_inc == r_sweeps)) ? COUNT : WHITE;
      COUNT:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < N; k++) begin
      w_pop = w_pop + MW'(r_spins[k]);
    end
    w_magnet  = (w_pop << 1) - MW'(N);
    w_rd_spin = (int'(rd_addr) < N) ? r_spins[rd_addr] : SPIN_DOWN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Only the active colour is written each phase; the other colour holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_spins     <= {N{SPIN_UP}};
      r_lfsr      <= SEED;
      r_sweep_cnt <= '0;
      r_sweeps    <= '0;
      r_thr4      <= '0;
      r_thr8      <= '0;
      r_magnet    <= '0;
      r_aborted   <= 1'b0;
      r_rd_spin   <= 1'b0;
    end else begin
      r_rd_spin <= w_rd_spin;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (init_en) r_spins <= {N{init_val}};
            if (seed_we) r_lfsr <= (seed == '0) ? SEED : seed;
            r_sweeps    <= sweeps;
            r_thr4      <= thr4;
            r_thr8      <= thr8;
            r_sweep_cnt <= '0;
            r_aborted   <= 1'b0;
          end
        end
        WHITE: begin
          r_spins <= (w_new & WHITE_MASK) | (r_spins & ~WHITE_MASK);
          r_lfsr  <= lfsr_next(r_lfsr);
          if (abort) r_aborted <= 1'b1;
        end
        GREY: begin
          r_spins     <= (w_new & ~WHITE_MASK) | (r_spins & WHITE_MASK);
          r_lfsr      <= lfsr_next(r_lfsr);
          r_sweep_cnt <= w_cnt_inc;
          if (abort) r_aborted <= 1'b1;
        end
        COUNT: r_magnet <= w_magnet;
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == WHITE) || (r_state == GREY) || (r_state == COUNT);
  assign done    = (r_state == DONE);
  assign aborted = r_aborted;
  assign rd_spin = r_rd_spin;
  assign magnet  = r_magnet;

endmodule

// File: tb/tb_ising_lattice_engine.sv
// Directed self-checking bench for ising_lattice_engine with an independent
// spin-arithmetic reference model for the random-acceptance sweeps.
module tb_ising_lattice_engine;

  localparam int          SIDE = 8;
  localparam int          N    = 64;
  localparam int          AW   = 6;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;
  localparam logic [31:0] BT4  = 32'h81AF_7C3D;
  localparam logic [31:0] BT8  = 32'h41B8_2E90;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, init_en, init_val, seed_we;
  logic [31:0]       seed, thr4, thr8;
  logic [15:0]       sweeps;
  logic [AW-1:0]     rd_addr;
  logic              rd_spin, busy, done, aborted;
  logic signed [7:0] magnet;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [N-1:0] tb_lat;
  logic [31:0]  tb_lfsr;

  always #5 clk = ~clk;

  ising_lattice_engine #(.SIDE(SIDE), .SWEEPS_W(16), .SEED(SEED), .AW(AW)) dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .init_en(init_en), .init_val(init_val), .seed_we(seed_we), .seed(seed),
    .sweeps(sweeps), .thr4(thr4), .thr8(thr8), .rd_addr(rd_addr),
    .rd_spin(rd_spin), .busy(busy), .done(done), .aborted(aborted), .magnet(magnet)
  );

  function automatic logic [31:0] m_rand(input logic [31:0] x, input int idx);
    logic [31:0] rot;
    int          k;
    k = idx % 32;
    for (int b = 0; b < 32; b++) rot[(b + k) % 32] = x[b];
    return rot ^ (32'(idx) * 32'h9E37_79B9);
  endfunction

  function automatic logic [31:0] m_adv(input logic [31:0] x);
    logic fb;
    fb = x[0];
    x  = x >> 1;
    if (fb) x = x ^ 32'h8020_0003;
    return x;
  endfunction

  task automatic m_phase(input bit white, input logic [31:0] t4, input logic [31:0] t8);
    logic [N-1:0] old;
    int s, sum, de, idx;
    logic [31:0] r;
    bit acc;
    old = tb_lat;
    for (int i = 0; i < SIDE; i++) begin
      for (int j = 0; j < SIDE; j++) begin
        if ((((i + j) % 2) == 0) == white) begin
          idx = i * SIDE + j;
          s   = old[idx] ? 1 : -1;
          sum = 0;
          sum += old[((i + SIDE - 1) % SIDE) * SIDE + j] ? 1 : -1;
          sum += old[((i + 1) % SIDE) * SIDE + j] ? 1 : -1;
          sum += old[i * SIDE + (j + SIDE - 1) % SIDE] ? 1 : -1;
          sum += old[i * SIDE + (j + 1) % SIDE] ? 1 : -1;
          de  = 2 * s * sum;
          r   = m_rand(tb_lfsr, idx);
          acc = (de <= 0) ||
                (de == 4 && (r < t4 || t4 == 32'hFFFF_FFFF)) ||
                (de == 8 && (r < t8 || t8 == 32'hFFFF_FFFF));
          if (acc) tb_lat[idx] = ~old[idx];
        end
      end
    end
    tb_lfsr = m_adv(tb_lfsr);
  endtask

  task automatic launch(input logic ie, input logic iv, input logic swe, input logic [31:0] sd,
                        input logic [15:0] nsw, input logic [31:0] t4, input logic [31:0] t8);
    @(negedge clk);
    init_en = ie; init_val = iv; seed_we = swe; seed = sd;
    sweeps = nsw; thr4 = t4; thr8 = t8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called one cycle after the start cycle; returns cycles since start or -1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    vectors += 5;
    if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)    begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (aborted !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_aborted: got %b expected 0", aborted); end
    if (magnet !== 8'sd0) begin miscompares++; $display("[TB] FAIL reset_magnet: got %0d expected 0", magnet); end
    if (rd_spin !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_spin: got %b expected 0", rd_spin); end
  endtask

  task automatic test_no_flips();
    int lat;
    launch(1'b1, 1'b1, 1'b0, 32'h0, 16'd3, 32'h0, 32'h0);
    wait_done(lat);
    vectors += 3;
    if (lat !== 8)         begin miscompares++; $display("[TB] FAIL noflip_latency: got %0d expected 8", lat); end
    if (aborted !== 1'b0)  begin miscompares++; $display("[TB] FAIL noflip_aborted: got %b expected 0", aborted); end
    if (magnet !== 8'sd64) begin miscompares++; $display("[TB] FAIL noflip_magnet: got %0d expected 64", magnet); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL noflip_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_all_flip();
    launch(1'b1, 1'b1, 1'b0, 32'h0, 16'd1, 32'h0, 32'hFFFF_FFFF);
    thr8 = 32'h0;
    @(negedge clk);
    rd_addr = AW'(1);
    @(negedge clk);
    vectors += 2;
    if (rd_spin !== 1'b1) begin miscompares++; $display("[TB] FAIL allflip_grey_held: got %b expected 1", rd_spin); end
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL allflip_count_state: got busy=%b done=%b expected 1 0", busy, done);
    end
    @(negedge clk);
    vectors += 2;
    if (done !== 1'b1)      begin miscompares++; $display("[TB] FAIL allflip_done: got %b expected 1", done); end
    if (magnet !== -8'sd64) begin miscompares++; $display("[TB] FAIL allflip_magnet: got %0d expected -64", magnet); end
    rd_addr = AW'(0);
    @(negedge clk);
    vectors++;
    if (rd_spin !== 1'b0) begin miscompares++; $display("[TB] FAIL allflip_read0: got %b expected 0", rd_spin); end
    rd_addr = AW'(9);
    @(negedge clk);
    vectors++;
    if (rd_spin !== 1'b0) begin miscompares++; $display("[TB] FAIL allflip_read9: got %b expected 0", rd_spin); end
  endtask

  task automatic test_abort();
    launch(1'b1, 1'b1, 1'b0, 32'h0, 16'd100, 32'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++; $display("[TB] FAIL abort_run_c%0d: got busy=%b done=%b expected 1 0", c, busy, done);
      end
      start = (c == 2);
      if (c == 2) sweeps = 16'd0;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL abort_count: got busy=%b done=%b expected 1 0", busy, done);
    end
    @(negedge clk);
    vectors += 3;
    if (done !== 1'b1)     begin miscompares++; $display("[TB] FAIL abort_done: got %b expected 1", done); end
    if (aborted !== 1'b1)  begin miscompares++; $display("[TB] FAIL abort_flag: got %b expected 1", aborted); end
    if (magnet !== 8'sd64) begin miscompares++; $display("[TB] FAIL abort_magnet: got %0d expected 64", magnet); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL abort_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_zero_sweeps();
    launch(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 16'd0, 32'h0, 32'h0);
    tb_lat = '0;
    abort  = 1'b1;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("[TB] FAIL zero_count: got busy=%b done=%b expected 1 0", busy, done);
    end
    @(negedge clk);
    abort = 1'b0;
    vectors += 3;
    if (done !== 1'b1)      begin miscompares++; $display("[TB] FAIL zero_done: got %b expected 1", done); end
    if (aborted !== 1'b0)   begin miscompares++; $display("[TB] FAIL zero_aborted: got %b expected 0", aborted); end
    if (magnet !== -8'sd64) begin miscompares++; $display("[TB] FAIL zero_magnet: got %0d expected -64", magnet); end
  endtask

  task automatic test_model(input string name, input logic ie, input logic iv, input logic swe,
                            input logic [31:0] sd);
    int lat, exp_m;
    if (ie)  tb_lat  = {N{iv}};
    if (swe) tb_lfsr = (sd == 32'h0) ? SEED : sd;
    m_phase(1'b1, BT4, BT8);
    m_phase(1'b0, BT4, BT8);
    exp_m = 2 * $countones(tb_lat) - N;
    launch(ie, iv, swe, sd, 16'd1, BT4, BT8);
    wait_done(lat);
    vectors += 2;
    if (lat !== 4) begin miscompares++; $display("[TB] FAIL %s_latency: got %0d expected 4", name, lat); end
    if (int'(magnet) !== exp_m) begin
      miscompares++; $display("[TB] FAIL %s_magnet: got %0d expected %0d", name, magnet, exp_m);
    end
    for (int k = 0; k < N; k++) begin
      rd_addr = AW'(k);
      @(negedge clk);
      vectors++;
      if (rd_spin !== tb_lat[k]) begin
        miscompares++; $display("[TB] FAIL %s_site%0d: got %b expected %b", name, k, rd_spin, tb_lat[k]);
      end
    end
  endtask

  task automatic test_midrun_reset();
    rd_addr = AW'(1);
    launch(1'b1, 1'b1, 1'b0, 32'h0, 16'd100, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (rd_spin !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rst_prerun: got rd_spin=%b busy=%b expected 1 1", rd_spin, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors += 4;
    if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    if (rd_spin !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rd_spin: got %b expected 0", rd_spin); end
    if (magnet !== 8'sd0) begin miscompares++; $display("[TB] FAIL rst_magnet: got %0d expected 0", magnet); end
    if (done !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
    @(negedge clk);
    rst_n   = 1'b1;
    rd_addr = AW'(0);
    @(negedge clk);
    vectors += 2;
    if (rd_spin !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_lattice0: got %b expected 1", rd_spin); end
    if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_idle: got %b expected 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; init_en = 1'b0; init_val = 1'b0;
    seed_we = 1'b0; seed = 32'h0; sweeps = 16'd0; thr4 = 32'h0; thr8 = 32'h0;
    rd_addr = '0; tb_lat = '1; tb_lfsr = SEED;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_no_flips();
    test_all_flip();
    test_abort();
    test_model("model_seed0", 1'b1, 1'b1, 1'b1, 32'h0);
    test_zero_sweeps();
    test_model("model_hold", 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
